// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN-ordered call latch and single-target dispatcher with dwell and move watchdog
module elevator_call_scheduler #(
   parameter  int N_FLOORS     = 4,
   parameter  int DWELL_CYCLES = 4,
   parameter  int MOVE_TIMEOUT = 64,
   localparam int FLOOR_W      = $clog2(N_FLOORS)
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic [N_FLOORS-1:0] i_call,
   input  logic [FLOOR_W-1:0]  i_current_floor,
   output logic [FLOOR_W-1:0]  o_target_floor,
   output logic [N_FLOORS-1:0] o_pending,
   output logic                o_busy,
   output logic                o_arrived,
   output logic                o_fault
);
   localparam int MOVE_W  = $clog2(MOVE_TIMEOUT);
   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [MOVE_W-1:0]  MOVE_LAST  = MOVE_W'(MOVE_TIMEOUT - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   state_t              state_q, state_d;
   dir_t                dir_q, dir_d;
   logic [FLOOR_W-1:0]  target_q, target_d;
   logic [N_FLOORS-1:0] pending_q, pending_d;
   logic [MOVE_W-1:0]   move_cnt_q, move_cnt_d;
   logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
   logic                arrived_q, arrived_d;
   logic                fault_q, fault_d;
   logic [N_FLOORS-1:0] clr_mask;

   logic [FLOOR_W-1:0]  lo_ge, hi_lt, hi_le, lo_gt;
   logic                lo_ge_ok, hi_le_ok;
   logic [FLOOR_W-1:0]  sel_floor;
   dir_t                sel_dir;

   // Four SCAN candidates relative to the current floor, then pick by direction.
   always_comb begin
      lo_ge    = '0;
      hi_lt    = '0;
      hi_le    = '0;
      lo_gt    = '0;
      lo_ge_ok = 1'b0;
      hi_le_ok = 1'b0;
      for (int f = 0; f < N_FLOORS; f++) begin
         if (pending_q[f] && FLOOR_W'(f) < i_current_floor) hi_lt = FLOOR_W'(f);
         if (pending_q[f] && FLOOR_W'(f) <= i_current_floor) begin
            hi_le    = FLOOR_W'(f);
            hi_le_ok = 1'b1;
         end
      end
      for (int f = N_FLOORS - 1; f >= 0; f--) begin
         if (pending_q[f] && FLOOR_W'(f) > i_current_floor) lo_gt = FLOOR_W'(f);
         if (pending_q[f] && FLOOR_W'(f) >= i_current_floor) begin
            lo_ge    = FLOOR_W'(f);
            lo_ge_ok = 1'b1;
         end
      end
      if (dir_q == DIR_UP) begin
         sel_floor = lo_ge_ok ? lo_ge : hi_lt;
         sel_dir   = lo_ge_ok ? DIR_UP : DIR_DOWN;
      end else begin
         sel_floor = hi_le_ok ? hi_le : lo_gt;
         sel_dir   = hi_le_ok ? DIR_DOWN : DIR_UP;
      end
   end

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      target_d    = target_q;
      move_cnt_d  = move_cnt_q;
      dwell_cnt_d = dwell_cnt_q;
      arrived_d   = 1'b0;
      fault_d     = fault_q;
      clr_mask    = '0;
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               target_d   = sel_floor;
               dir_d      = sel_dir;
               move_cnt_d = '0;
               state_d    = MOVE;
            end
         end
         MOVE: begin
            if (i_current_floor == target_q) begin
               clr_mask    = N_FLOORS'(1) << target_q;
               arrived_d   = 1'b1;
               dwell_cnt_d = DWELL_LAST;
               state_d     = DWELL;
            end else if (move_cnt_q == MOVE_LAST) begin
               clr_mask = N_FLOORS'(1) << target_q;
               fault_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               move_cnt_d = move_cnt_q + 1'b1;
            end
         end
         DWELL: begin
            if (dwell_cnt_q == '0) state_d = IDLE;
            else dwell_cnt_d = dwell_cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // A clear beats a same-cycle call for the served floor.
      pending_d = (pending_q | i_call) & ~clr_mask;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= IDLE;
         dir_q       <= DIR_UP;
         target_q    <= '0;
         pending_q   <= '0;
         move_cnt_q  <= '0;
         dwell_cnt_q <= '0;
         arrived_q   <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         target_q    <= target_d;
         pending_q   <= pending_d;
         move_cnt_q  <= move_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         arrived_q   <= arrived_d;
         fault_q     <= fault_d;
      end
   end

   assign o_target_floor = target_q;
   assign o_pending      = pending_q;
   assign o_busy         = (state_q != IDLE);
   assign o_arrived      = arrived_q;
   assign o_fault        = fault_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed and randomized self-checking bench for elevator_call_scheduler
module tb_elevator_call_scheduler;
   localparam int N     = 4;
   localparam int DWELL = 4;
   localparam int TMO   = 64;
   localparam int STEP  = 10;

   logic         i_clock = 1'b0;
   logic         i_reset = 1'b1;
   logic [N-1:0] i_call  = '0;
   logic [1:0]   cur_floor = 2'd0;
   logic [1:0]   o_target_floor;
   logic [N-1:0] o_pending;
   logic         o_busy, o_arrived, o_fault;

   elevator_call_scheduler #(.N_FLOORS(N), .DWELL_CYCLES(DWELL), .MOVE_TIMEOUT(TMO)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_call(i_call), .i_current_floor(cur_floor),
      .o_target_floor(o_target_floor), .o_pending(o_pending), .o_busy(o_busy),
      .o_arrived(o_arrived), .o_fault(o_fault)
   );

   always #5 i_clock = ~i_clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 travelling, 2 dwelling
   int           m_mode = 0;
   bit           m_up = 1'b1;
   int           m_target = 0;
   logic [N-1:0] m_pending = '0;
   bit           m_arrived = 1'b0;
   bit           m_fault = 1'b0;
   int           m_age = 0;
   int           m_dwell_left = 0;

   task automatic scan_pick(input logic [N-1:0] p, input int c, input bit up, output int t, output bit up_n);
      t = -1;
      up_n = up;
      if (up) begin
         for (int f = c; f < N; f++) if (p[f] && t < 0) t = f;
         if (t < 0) begin
            for (int f = c - 1; f >= 0; f--) if (p[f] && t < 0) t = f;
            up_n = 1'b0;
         end
      end else begin
         for (int f = c; f >= 0; f--) if (p[f] && t < 0) t = f;
         if (t < 0) begin
            for (int f = c + 1; f < N; f++) if (p[f] && t < 0) t = f;
            up_n = 1'b1;
         end
      end
   endtask

   task automatic model_step();
      logic [N-1:0] clr;
      int t;
      bit up_n;
      clr = '0;
      if (i_reset) begin
         m_mode = 0; m_up = 1'b1; m_target = 0; m_pending = '0;
         m_arrived = 1'b0; m_fault = 1'b0; m_age = 0; m_dwell_left = 0;
      end else begin
         m_arrived = 1'b0;
         case (m_mode)
            0: if (m_pending != '0) begin
               scan_pick(m_pending, int'(cur_floor), m_up, t, up_n);
               m_target = t; m_up = up_n; m_mode = 1; m_age = 0;
            end
            1: if (int'(cur_floor) == m_target) begin
               clr[m_target] = 1'b1; m_arrived = 1'b1; m_mode = 2; m_dwell_left = DWELL;
            end else if (m_age == TMO - 1) begin
               clr[m_target] = 1'b1; m_fault = 1'b1; m_mode = 0;
            end else begin
               m_age++;
            end
            default: begin
               m_dwell_left--;
               if (m_dwell_left == 0) m_mode = 0;
            end
         endcase
         m_pending = (m_pending | i_call) & ~clr;
      end
   endtask

   initial forever begin
      @(posedge i_clock);
      model_step();
   end

   bit   chk_en = 1'b0;
   bit   freeze = 1'b0;
   bit   prev_busy = 1'b0;
   int   step_cnt = 0;
   int   arr_cnt = 0;
   int   disp_q[$];

   // Per-cycle compare, dispatch/arrival monitor and elevator car model
   initial forever begin
      @(negedge i_clock);
      if (chk_en) begin
         check("target", int'(o_target_floor), m_target);
         check("pending", int'(o_pending), int'(m_pending));
         check("busy", int'(o_busy), int'(m_mode != 0));
         check("arrived", int'(o_arrived), int'(m_arrived));
         check("fault", int'(o_fault), int'(m_fault));
         if (o_busy && !prev_busy) disp_q.push_back(int'(o_target_floor));
         if (o_arrived) arr_cnt++;
      end
      prev_busy = o_busy;
      if (!freeze && cur_floor != o_target_floor) begin
         step_cnt++;
         if (step_cnt == STEP) begin
            step_cnt = 0;
            cur_floor = (cur_floor < o_target_floor) ? cur_floor + 2'd1 : cur_floor - 2'd1;
         end
      end else begin
         step_cnt = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clock);
   endtask

   task automatic pulse_call(input logic [N-1:0] v);
      @(negedge i_clock);
      i_call = v;
      @(negedge i_clock);
      i_call = '0;
   endtask

   task automatic wait_quiet(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge i_clock);
         if (!o_busy && o_pending == '0) ok = 1'b1;
      end
      check(name, int'(ok), 1);
   endtask

   task automatic wait_arrival(input string name, input int bound);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge i_clock);
         if (o_arrived) ok = 1'b1;
      end
      check(name, int'(ok), 1);
   endtask

   task automatic busy_tail(input string name);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clock);
         cnt++;
         if (!o_busy) break;
      end
      check(name, cnt, DWELL);
   endtask

   initial begin
      int cnt;
      bit seen;
      // 1: reset
      i_reset = 1'b1;
      @(negedge i_clock);
      chk_en = 1'b1;
      @(negedge i_clock);
      check("rst_target", int'(o_target_floor), 0);
      check("rst_pending", int'(o_pending), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_arrived", int'(o_arrived), 0);
      check("rst_fault", int'(o_fault), 0);
      i_reset = 1'b0;
      tick(2);

      // 2: single call to floor 2 from floor 0
      pulse_call(4'b0100);
      check("t2_pending_latched", int'(o_pending), 4'b0100);
      check("t2_target_not_yet", int'(o_target_floor), 0);
      @(negedge i_clock);
      check("t2_target", int'(o_target_floor), 2);
      check("t2_busy", int'(o_busy), 1);
      wait_arrival("t2_arrival_seen", 40);
      check("t2_pending_cleared", int'(o_pending), 0);
      busy_tail("t2_dwell_len");

      // 3: SCAN ordering, first steer to floor 1 heading up
      pulse_call(4'b0010); wait_quiet("t3_setup_a");
      pulse_call(4'b0001); wait_quiet("t3_setup_b");
      pulse_call(4'b0010); wait_quiet("t3_setup_c");
      check("t3_model_dir_up", int'(m_up), 1);
      disp_q.delete();
      arr_cnt = 0;
      pulse_call(4'b1001);
      wait_quiet("t3_done");
      check("t3_dispatch_count", disp_q.size(), 2);
      check("t3_order", int'(disp_q.size() == 2 && disp_q[0] == 3 && disp_q[1] == 0), 1);
      check("t3_arrivals", arr_cnt, 2);
      check("t3_model_dir_down", int'(m_up), 0);

      // 4: same-floor call at floor 0
      pulse_call(4'b0001);
      @(negedge i_clock);
      check("t4_target", int'(o_target_floor), 0);
      check("t4_busy", int'(o_busy), 1);
      check("t4_no_arrival_yet", int'(o_arrived), 0);
      @(negedge i_clock);
      check("t4_arrived", int'(o_arrived), 1);
      check("t4_pending", int'(o_pending), 0);
      busy_tail("t4_dwell_len");

      // 5a: call held through arrival re-latches after the clear
      disp_q.delete();
      @(negedge i_clock);
      i_call = 4'b0100;
      wait_arrival("t5_arrival_seen", 60);
      check("t5_clear_wins", int'(o_pending), 0);
      @(negedge i_clock);
      check("t5_relatched", int'(o_pending), 4'b0100);
      i_call = '0;
      wait_quiet("t5_done");
      check("t5_dispatch_count", disp_q.size(), 2);
      check("t5_both_floor2", int'(disp_q.size() == 2 && disp_q[0] == 2 && disp_q[1] == 2), 1);

      // 5b: frozen car trips the watchdog
      freeze = 1'b1;
      pulse_call(4'b1000);
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge i_clock);
         if (o_fault) seen = 1'b1;
         else if (o_busy) cnt++;
      end
      check("t5_fault_seen", int'(seen), 1);
      check("t5_move_cycles", cnt, TMO);
      check("t5_fault_pending", int'(o_pending), 0);
      check("t5_fault_idle", int'(o_busy), 0);
      freeze = 1'b0;
      tick(5);
      check("t5_fault_sticky", int'(o_fault), 1);

      // 6: reset mid-trip 0 -> 3
      i_reset = 1'b1;
      tick(2);
      i_reset = 1'b0;
      check("t6_fault_cleared", int'(o_fault), 0);
      tick(40);
      pulse_call(4'b1000);
      tick(15);
      check("t6_moving", int'(o_busy), 1);
      i_reset = 1'b1;
      @(negedge i_clock);
      check("t6_target", int'(o_target_floor), 0);
      check("t6_pending", int'(o_pending), 0);
      check("t6_busy", int'(o_busy), 0);
      check("t6_arrived", int'(o_arrived), 0);
      check("t6_fault", int'(o_fault), 0);
      i_reset = 1'b0;
      arr_cnt = 0;
      tick(50);
      check("t6_no_arrival", arr_cnt, 0);
      check("t6_pending_after", int'(o_pending), 0);

      // Randomized traffic with occasional stalls and resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge i_clock);
         i_reset = ($urandom_range(0, 1499) == 0);
         i_call  = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
         freeze  = ((cyc % 700) >= 600);
      end
      @(negedge i_clock);
      i_call = '0;
      i_reset = 1'b0;
      freeze = 1'b0;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
      $fatal(1, "bench timed out");
   end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Collects per-floor call requests, latches them, and dispatches one target floor at a time to the elevator core. Its o_target_floor drives the core's i_buttons; the core's o_current_floor feeds back into i_current_floor.
- Uses SCAN (elevator-algorithm) ordering, a post-arrival dwell interval and a per-trip watchdog.
- Sits between the hall/car button logic and the elevator core.

Parameters:
- N_FLOORS, 4, number of floors; valid range 2..16.
- FLOOR_W, $clog2(N_FLOORS), floor index width; derived, never overridden.
- DWELL_CYCLES, 4, cycles spent in DWELL after arrival; must be >= 1.
- MOVE_TIMEOUT, 64, maximum cycles in MOVE before a fault is declared; must be >= 2.

Ports:
- i_clock  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_call  input  N_FLOORS  per-floor call request, level or pulse; bit f requests floor f.
- i_current_floor  input  FLOOR_W  floor currently reported by the elevator core.
- o_target_floor  output  FLOOR_W  floor being dispatched; connects to the elevator core's i_buttons.
- o_pending  output  N_FLOORS  latched outstanding requests.
- o_busy  output  1  high whenever state != IDLE.
- o_arrived  output  1  one-cycle pulse on arrival at the target.
- o_fault  output  1  sticky watchdog fault.

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE, dir=UP.
  - o_target_floor=0, o_pending=0, o_arrived=0, o_fault=0, all counters 0.
  - Reset asserted mid-MOVE or mid-DWELL abandons the trip; the next edge after reset deassertion starts from IDLE.
- Request latch: every edge, pending <= (pending | i_call) & ~clr_mask.
  - clr_mask is one-hot on o_target_floor only in the cycle arrival or timeout is detected, else 0.
  - Clear wins over a simultaneous call for that same floor; the call is dropped as served.
- States: IDLE, MOVE, DWELL.
- IDLE: if pending != 0, select a target, register it into o_target_floor, and go to MOVE on the same edge, with move_cnt=0.
  - Latency: a call sampled at edge N appears in o_pending after N and in o_target_floor after N+1.
- Target selection (SCAN, from i_current_floor=c):
  - dir=UP: choose the lowest pending floor >= c. If none, choose the highest pending floor < c and set dir=DOWN.
  - dir=DOWN: choose the highest pending floor <= c. If none, choose the lowest pending floor > c and set dir=UP.
  - A pending request at c itself is always chosen first.
- MOVE: target is held; the schedule is non-preemptive, so new calls only latch.
  - If i_current_floor == o_target_floor: clear pending[target], o_arrived=1 for exactly the next cycle, go to DWELL with dwell_cnt=DWELL_CYCLES-1.
  - Else, if move_cnt == MOVE_TIMEOUT-1: set o_fault=1 (sticky until reset), clear pending[target], go to IDLE.
  - Else move_cnt++.
- DWELL: decrement dwell_cnt; at 0 go to IDLE.
  - DWELL lasts exactly DWELL_CYCLES cycles.
  - Calls arriving during DWELL are latched.
- After a fault, scheduling continues normally; o_fault only reports the event.
- o_target_floor changes only on the IDLE->MOVE transition; otherwise it is held, including during DWELL and IDLE.
- Call for an out-of-range floor: not possible by width, since i_call has exactly N_FLOORS bits.

Test Plan:
Use N_FLOORS=4, DWELL_CYCLES=4, MOVE_TIMEOUT=64, driving a behavioural elevator model that moves one floor per 10 cycles.
1. Reset: hold i_reset for 2 cycles -> o_target_floor=0, o_pending=0, o_busy=0, o_arrived=0, o_fault=0.
2. Single call: at floor 0, pulse i_call=4'b0100 for one cycle -> o_pending=0100 next cycle; o_target_floor=2 one cycle later, o_busy=1; ~20 cycles later o_arrived pulses once, o_pending=0000; o_busy drops 4 cycles after arrival.
3. SCAN order: at floor 1 with dir=UP, pulse i_call=4'b1001 -> targets issued in order 3 then 0; o_arrived pulses twice; dir=DOWN after the second dispatch.
4. Same-floor call: idle at floor 0, pulse i_call=4'b0001 -> o_target_floor=0; o_arrived pulses 1 cycle after dispatch; DWELL then IDLE.
5. Clear vs call collision and watchdog:
   - Hold i_call[2] high through the arrival cycle at floor 2 -> pending[2] is cleared on the arrival edge and re-set on the following edge, causing a second dispatch to floor 2.
   - Separately, freeze the elevator model's floor -> o_fault=1 after 64 MOVE cycles, pending bit cleared, state IDLE.
6. Reset mid-MOVE: assert i_reset while travelling 0->3 -> all outputs 0 next cycle; no o_arrived pulse; o_pending empty.
